// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: mode/opcode/command/condition encodings and the control-word layout
// shared by control_decode and control_unit_pipe.
package arm_ctrl_pkg;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic       s;
    logic       b;
    logic       mem_w_en;
    logic       mem_r_en;
    logic       wb_en;
    logic [3:0] exe_cmd;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // ARM condition evaluation against {N,Z,C,V}; NV never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: purely combinational decode of op_code/mode/s_in into a control word.
module control_decode
  import arm_ctrl_pkg::*;
(
  input  logic [3:0]        op_code_i,
  input  logic [1:0]        mode_i,
  input  logic              s_in_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t ctrl_s;

  // Opcode/mode table; anything unlisted falls through to an all-zero NOP (s still follows s_in).
  always_comb begin
    ctrl_s   = '0;
    ctrl_s.s = s_in_i;
    case (mode_i)
      MODE_ALU: begin
        case (op_code_i)
          OP_MOV: begin ctrl_s.exe_cmd = EXE_MOV; ctrl_s.wb_en = 1'b1; end
          OP_MVN: begin ctrl_s.exe_cmd = EXE_MVN; ctrl_s.wb_en = 1'b1; end
          OP_ADD: begin ctrl_s.exe_cmd = EXE_ADD; ctrl_s.wb_en = 1'b1; end
          OP_ADC: begin ctrl_s.exe_cmd = EXE_ADC; ctrl_s.wb_en = 1'b1; end
          OP_SUB: begin ctrl_s.exe_cmd = EXE_SUB; ctrl_s.wb_en = 1'b1; end
          OP_SBC: begin ctrl_s.exe_cmd = EXE_SBC; ctrl_s.wb_en = 1'b1; end
          OP_AND: begin ctrl_s.exe_cmd = EXE_AND; ctrl_s.wb_en = 1'b1; end
          OP_ORR: begin ctrl_s.exe_cmd = EXE_ORR; ctrl_s.wb_en = 1'b1; end
          OP_EOR: begin ctrl_s.exe_cmd = EXE_EOR; ctrl_s.wb_en = 1'b1; end
          OP_CMP: ctrl_s.exe_cmd = EXE_SUB;
          OP_TST: ctrl_s.exe_cmd = EXE_AND;
          default: ctrl_s.exe_cmd = EXE_NOP;
        endcase
      end
      MODE_MEM: begin
        ctrl_s.exe_cmd = EXE_ADD;
        if (s_in_i) begin
          ctrl_s.mem_r_en = 1'b1;
          ctrl_s.wb_en    = 1'b1;
        end else begin
          ctrl_s.mem_w_en = 1'b1;
        end
      end
      MODE_BR:  ctrl_s.b = 1'b1;
      MODE_RSV: ctrl_s.exe_cmd = EXE_NOP;
      default:  ctrl_s.exe_cmd = EXE_NOP;
    endcase
  end

  assign ctrl_o = ctrl_s;

endmodule

// File: rtl/control_unit_pipe.sv
// control_unit_pipe: registered ID/EXE control pipeline (DEPTH stages) with valid tracking,
// stall, flush and branch-shadow squashing. Optional feature macro: CONTROL_UNIT_COND_CHECK_EN.
module control_unit_pipe
  import arm_ctrl_pkg::*;
#(
  parameter int DEPTH     = 1,
  parameter int EXE_CMD_W = 4,
  parameter int BR_SHADOW = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [3:0]           op_code,
  input  logic [1:0]           mode,
  input  logic                 s_in,
  input  logic [3:0]           cond,
  input  logic [3:0]           status_nzcv,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic                 s,
  output logic                 b,
  output logic                 mem_w_en,
  output logic                 mem_r_en,
  output logic                 wb_en,
  output logic [EXE_CMD_W-1:0] exe_cmd
);

  localparam int SH_W = (BR_SHADOW > 0) ? $clog2(BR_SHADOW + 1) : 1;
  localparam logic [SH_W-1:0] SH_LOAD = SH_W'(BR_SHADOW);

  logic [CTRL_W-1:0] dec_raw_s;
  ctrl_t             dec_s;
  logic              cond_ok_s;
  logic              accept_s;
  logic              squash_s;
  ctrl_t             stage_in_d;
  logic              vld_in_d;
  logic [SH_W-1:0]   shadow_cnt_d;
  logic [SH_W-1:0]   shadow_cnt_q;
  ctrl_t             ctrl_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  ctrl_t             last_s;
  logic [3:0]        cmd_gated_s;

  control_decode u_decode (
    .op_code_i (op_code),
    .mode_i    (mode),
    .s_in_i    (s_in),
    .ctrl_o    (dec_raw_s)
  );

  assign dec_s = ctrl_t'(dec_raw_s);

`ifdef CONTROL_UNIT_COND_CHECK_EN
  assign cond_ok_s = cond_pass(cond, status_nzcv);
`else
  logic unused_cond_s;
  assign cond_ok_s     = 1'b1;
  assign unused_cond_s = ^{cond, status_nzcv};
`endif

  assign accept_s = in_valid & ~stall & ~flush;
  assign squash_s = (shadow_cnt_q != '0);

  // Stage-1 contents and shadow counter update; squashed slots carry valid=0 and a zero word.
  always_comb begin
    stage_in_d   = '0;
    vld_in_d     = 1'b0;
    shadow_cnt_d = shadow_cnt_q;
    if (flush) begin
      shadow_cnt_d = '0;
    end else if (accept_s) begin
      if (squash_s) begin
        shadow_cnt_d = shadow_cnt_q - SH_W'(1);
      end else if (cond_ok_s) begin
        vld_in_d   = 1'b1;
        stage_in_d = dec_s;
        if (dec_s.b) begin
          shadow_cnt_d = SH_LOAD;
        end else begin
          shadow_cnt_d = shadow_cnt_q;
        end
      end else begin
        // Condition failed: keep the slot as a valid NOP, no shadow load.
        vld_in_d = 1'b1;
      end
    end else begin
      shadow_cnt_d = shadow_cnt_q;
    end
  end

  // Stage registers: flush beats stall, stall freezes everything including the shadow counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      shadow_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
      end
    end else if (flush) begin
      vld_q        <= '0;
      shadow_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
      end
    end else if (!stall) begin
      vld_q[0]     <= vld_in_d;
      ctrl_q[0]    <= stage_in_d;
      shadow_cnt_q <= shadow_cnt_d;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        ctrl_q[i] <= ctrl_q[i-1];
      end
    end
  end

  assign last_s      = ctrl_q[DEPTH-1];
  assign in_ready    = ~stall;
  assign out_valid   = vld_q[DEPTH-1];
  assign s           = out_valid & last_s.s;
  assign b           = out_valid & last_s.b;
  assign mem_w_en    = out_valid & last_s.mem_w_en;
  assign mem_r_en    = out_valid & last_s.mem_r_en;
  assign wb_en       = out_valid & last_s.wb_en;
  assign cmd_gated_s = last_s.exe_cmd & {4{out_valid}};
  assign exe_cmd     = EXE_CMD_W'(cmd_gated_s);

endmodule

// File: tb/tb_control_unit_pipe.sv
// Self-checking bench for control_unit_pipe: three configurations share one stimulus stream,
// each checked every cycle against a queue-style reference model plus directed sequences.
module tb_control_unit_pipe;

  typedef struct packed {
    logic       v;
    logic       s;
    logic       b;
    logic       mw;
    logic       mr;
    logic       wb;
    logic [3:0] cmd;
  } word_t;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] op;
    logic       s_in;
    word_t      exp;
  } vec_t;

  localparam int NI = 3;
  localparam int DEP [NI] = '{2, 3, 1};
  localparam int SHD [NI] = '{2, 0, 7};
  // {opcode, command, writeback} for the data-processing group
  localparam logic [8:0] ALU_TAB [11] = '{
    9'b1101_0001_1, 9'b1111_1001_1, 9'b0100_0010_1, 9'b0101_0011_1,
    9'b0010_0100_1, 9'b0110_0101_1, 9'b0000_0110_1, 9'b1100_0111_1,
    9'b0001_1000_1, 9'b1010_0100_0, 9'b1000_0110_0};

  logic clk = 1'b0;
  logic rst_n, in_valid, s_in, stall, flush;
  logic [1:0] mode;
  logic [3:0] op_code, cond, status_nzcv;
  logic [NI-1:0] rdy_w, ov_w, s_w, b_w, mw_w, mr_w, wb_w;
  logic [3:0] cmd_a, cmd_c;
  logic [5:0] cmd_b;

  int n_cmp = 0;
  int n_bad = 0;
  word_t mp [NI][4];
  int msh [NI];
  vec_t vt [17];
  word_t shexp [5];

  always #5 clk = ~clk;

  control_unit_pipe #(.DEPTH(2), .EXE_CMD_W(4), .BR_SHADOW(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op_code(op_code), .mode(mode), .s_in(s_in),
    .cond(cond), .status_nzcv(status_nzcv), .stall(stall), .flush(flush), .in_ready(rdy_w[0]),
    .out_valid(ov_w[0]), .s(s_w[0]), .b(b_w[0]), .mem_w_en(mw_w[0]), .mem_r_en(mr_w[0]),
    .wb_en(wb_w[0]), .exe_cmd(cmd_a));

  control_unit_pipe #(.DEPTH(3), .EXE_CMD_W(6), .BR_SHADOW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op_code(op_code), .mode(mode), .s_in(s_in),
    .cond(cond), .status_nzcv(status_nzcv), .stall(stall), .flush(flush), .in_ready(rdy_w[1]),
    .out_valid(ov_w[1]), .s(s_w[1]), .b(b_w[1]), .mem_w_en(mw_w[1]), .mem_r_en(mr_w[1]),
    .wb_en(wb_w[1]), .exe_cmd(cmd_b));

  control_unit_pipe #(.DEPTH(1), .EXE_CMD_W(4), .BR_SHADOW(7)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op_code(op_code), .mode(mode), .s_in(s_in),
    .cond(cond), .status_nzcv(status_nzcv), .stall(stall), .flush(flush), .in_ready(rdy_w[2]),
    .out_valid(ov_w[2]), .s(s_w[2]), .b(b_w[2]), .mem_w_en(mw_w[2]), .mem_r_en(mr_w[2]),
    .wb_en(wb_w[2]), .exe_cmd(cmd_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t actual(input int i);
    word_t w;
    w.v   = ov_w[i];
    w.s   = s_w[i];
    w.b   = b_w[i];
    w.mw  = mw_w[i];
    w.mr  = mr_w[i];
    w.wb  = wb_w[i];
    w.cmd = (i == 0) ? cmd_a : ((i == 1) ? cmd_b[3:0] : cmd_c);
    return w;
  endfunction

  function automatic word_t ref_decode(input logic [1:0] md, input logic [3:0] op, input logic sb);
    word_t w;
    logic [8:0] e;
    w   = '0;
    w.v = 1'b1;
    w.s = sb;
    if (md == 2'd0) begin
      for (int k = 0; k < 11; k++) begin
        e = ALU_TAB[k];
        if (e[8:5] == op) begin
          w.cmd = e[4:1];
          w.wb  = e[0];
        end
      end
    end else if (md == 2'd1) begin
      w.cmd = 4'd2;
      w.mr  = sb;
      w.wb  = sb;
      w.mw  = ~sb;
    end else if (md == 2'd2) begin
      w.b = 1'b1;
    end
    return w;
  endfunction

  // Condition pairs: even code tests a flag expression, odd code is its inverse; 1111 inverts AL.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] & ~f[2];
      3'd5: base = (f[3] == f[0]);
      3'd6: base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < 4; j++) mp[i][j] = '0;
      msh[i] = 0;
    end
  endtask

  task automatic model_step();
    word_t nw;
    logic ok;
    for (int i = 0; i < NI; i++) begin
      if (flush) begin
        for (int j = 0; j < 4; j++) mp[i][j] = '0;
        msh[i] = 0;
      end else if (!stall) begin
        nw = '0;
        if (in_valid) begin
          if (msh[i] > 0) begin
            msh[i]--;
          end else begin
            ok = 1'b1;
`ifdef CONTROL_UNIT_COND_CHECK_EN
            ok = ref_cond(cond, status_nzcv);
`endif
            if (!ok) begin
              nw.v = 1'b1;
            end else begin
              nw = ref_decode(mode, op_code, s_in);
              if (mode == 2'b10) msh[i] = SHD[i];
            end
          end
        end
        for (int j = 3; j > 0; j--) mp[i][j] = mp[i][j-1];
        mp[i][0] = nw;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s out%0d", tag, i), actual(i), mp[i][DEP[i]-1]);
      check($sformatf("%s rdy%0d", tag, i), rdy_w[i], !stall);
    end
    check($sformatf("%s cmd_hi", tag), cmd_b[5:4], 2'b00);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [1:0] md, input logic [3:0] op, input logic sb);
    in_valid = v;
    mode     = md;
    op_code  = op;
    s_in     = sb;
  endtask

  function automatic vec_t mkv(input logic [1:0] md, input logic [3:0] op, input logic sb,
                               input logic [9:0] e);
    vec_t r;
    r.mode = md;
    r.op   = op;
    r.s_in = sb;
    r.exp  = word_t'(e);
    return r;
  endfunction

  initial begin
    // expected words are {v,s,b,mw,mr,wb}_{cmd}
    vt[0]  = mkv(2'b00, 4'b1101, 1'b0, 10'b100001_0001);
    vt[1]  = mkv(2'b00, 4'b1111, 1'b1, 10'b110001_1001);
    vt[2]  = mkv(2'b00, 4'b0100, 1'b0, 10'b100001_0010);
    vt[3]  = mkv(2'b00, 4'b0101, 1'b1, 10'b110001_0011);
    vt[4]  = mkv(2'b00, 4'b0010, 1'b0, 10'b100001_0100);
    vt[5]  = mkv(2'b00, 4'b0110, 1'b1, 10'b110001_0101);
    vt[6]  = mkv(2'b00, 4'b0000, 1'b0, 10'b100001_0110);
    vt[7]  = mkv(2'b00, 4'b1100, 1'b1, 10'b110001_0111);
    vt[8]  = mkv(2'b00, 4'b0001, 1'b0, 10'b100001_1000);
    vt[9]  = mkv(2'b00, 4'b1010, 1'b1, 10'b110000_0100);
    vt[10] = mkv(2'b00, 4'b1000, 1'b0, 10'b100000_0110);
    vt[11] = mkv(2'b00, 4'b0011, 1'b0, 10'b100000_0000);
    vt[12] = mkv(2'b00, 4'b1011, 1'b1, 10'b110000_0000);
    vt[13] = mkv(2'b01, 4'b0000, 1'b1, 10'b110011_0010);
    vt[14] = mkv(2'b01, 4'b0000, 1'b0, 10'b100100_0010);
    vt[15] = mkv(2'b11, 4'b0100, 1'b1, 10'b110000_0000);
    vt[16] = mkv(2'b10, 4'b0100, 1'b0, 10'b101000_0000);

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    cond = 4'b1110; status_nzcv = 4'b0000;
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // decode table on the single-stage instance
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, vt[i].mode, vt[i].op, vt[i].s_in);
      cycle("tbl");
      check($sformatf("tbl vec%0d", i), actual(2), vt[i].exp);
    end
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    flush = 1'b1;
    cycle("flush");
    flush = 1'b0;

    // DEPTH=2 latency of a single ADD
    drive(1'b1, 2'b00, 4'b0100, 1'b0);
    cycle("add");
    check("add_after_e1", ov_w[0], 1'b0);
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    cycle("add");
    check("add_after_e2", actual(0), 10'b100001_0010);
    cycle("add");
    check("add_after_e3", ov_w[0], 1'b0);

    // branch shadow of 2 on instance A: B, SUB, ORR, MOV
    shexp[0] = '0; shexp[1] = word_t'(10'b101000_0000); shexp[2] = '0; shexp[3] = '0;
    shexp[4] = word_t'(10'b100001_0001);
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: drive(1'b1, 2'b10, 4'b0000, 1'b0);
        1: drive(1'b1, 2'b00, 4'b0010, 1'b0);
        2: drive(1'b1, 2'b00, 4'b1100, 1'b0);
        3: drive(1'b1, 2'b00, 4'b1101, 1'b0);
        default: drive(1'b0, 2'b00, 4'b0000, 1'b0);
      endcase
      cycle("shadow");
      check($sformatf("shadow step%0d", k), actual(0), shexp[k]);
    end
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    flush = 1'b1;
    cycle("flush");
    flush = 1'b0;

    // DEPTH=3 fill, stall 3 cycles, then stall+flush
    drive(1'b1, 2'b00, 4'b0100, 1'b0); cycle("fill");
    drive(1'b1, 2'b00, 4'b0010, 1'b0); cycle("fill");
    drive(1'b1, 2'b00, 4'b1101, 1'b0); cycle("fill");
    check("fill_head", actual(1), 10'b100001_0010);
    stall = 1'b1;
    drive(1'b1, 2'b00, 4'b0001, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle("stall");
      check($sformatf("stall hold%0d", k), actual(1), 10'b100001_0010);
    end
    flush = 1'b1;
    cycle("stflush");
    check("stall_flush ov", ov_w[1], 1'b0);
    stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cycle("drain");
      check($sformatf("post_flush ov%0d", k), actual(1), 10'b0);
    end

    // asynchronous reset between edges
    drive(1'b1, 2'b00, 4'b1101, 1'b0); cycle("rst_pre");
    drive(1'b0, 2'b00, 4'b0000, 1'b0); cycle("rst_pre");
    check("rst_ov_before", ov_w[0], 1'b1);
    #2;
    rst_n = 1'b0;
    stall = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) check($sformatf("rst_async out%0d", i), actual(i), 10'b0);
    check("rst_async rdy", rdy_w, 3'b000);
    check("rst_async cmd_hi", cmd_b, 6'b0);
    #1;
    stall = 1'b0;
    rst_n = 1'b1;
    model_reset();
    cycle("post_rst");

`ifdef CONTROL_UNIT_COND_CHECK_EN
    cond = 4'b0000; status_nzcv = 4'b0000;
    drive(1'b1, 2'b00, 4'b0100, 1'b0);
    cycle("cond");
    check("cond_eq_fail", actual(2), 10'b100000_0000);
    status_nzcv = 4'b0100;
    cycle("cond");
    check("cond_eq_pass", actual(2), 10'b100001_0010);
    cond = 4'b1111;
    cycle("cond");
    check("cond_nv", actual(2), 10'b100000_0000);
    cond = 4'b1110;
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    cycle("cond");
`endif

    // randomized stream against the reference model
    for (int n = 0; n < 1500; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 6) == 0);
      flush       = ($urandom_range(0, 24) == 0);
      mode        = 2'($urandom_range(0, 3));
      op_code     = 4'($urandom_range(0, 15));
      s_in        = 1'($urandom_range(0, 1));
      cond        = 4'($urandom_range(0, 15));
      status_nzcv = 4'($urandom_range(0, 15));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
